// File: rtl/difftest_step_batcher.sv
// Batches per-cycle progress ticks into single-cycle step pulses for the step controller.
// Emission is paced by a count threshold, an idle timeout or an explicit flush, and freezes on stop.
module difftest_step_batcher #(
  parameter int unsigned STEP_WIDTH      = 8,
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned ACC_WIDTH       = 16,
  parameter int unsigned BATCH_THRESHOLD = 64,
  parameter int unsigned TIMEOUT         = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick_valid,
  input  logic [IN_WIDTH-1:0]   tick_count,
  input  logic                  flush,
  input  logic                  stop,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  pending,
  output logic                  overflow,
  output logic [63:0]           emitted_total
);

  // Working width large enough for acc + tick without wrap and for the step ceiling.
  localparam int unsigned MaxW = (ACC_WIDTH > STEP_WIDTH) ?
                                 ((ACC_WIDTH > IN_WIDTH) ? ACC_WIDTH : IN_WIDTH) :
                                 ((STEP_WIDTH > IN_WIDTH) ? STEP_WIDTH : IN_WIDTH);
  localparam int unsigned WW = MaxW + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WW-1:0] AccMax  = (WW'(1) << ACC_WIDTH) - WW'(1);
  localparam logic [WW-1:0] StepMax = (WW'(1) << STEP_WIDTH) - WW'(1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccum   = 2'd1;
  localparam logic [1:0] StStopped = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  overflow_q, overflow_d;
  logic [63:0]           emitted_total_q, emitted_total_d;

  logic [WW-1:0] add_w, sum_w, acc_next_w, amt_w;
  logic          sat_hit, stopped, emit;

  always_comb begin
    add_w      = tick_valid ? WW'(tick_count) : '0;
    sum_w      = WW'(acc_q) + add_w;
    sat_hit    = (sum_w > AccMax);
    acc_next_w = sat_hit ? AccMax : sum_w;
    amt_w      = (acc_next_w > StepMax) ? StepMax : acc_next_w;
    // stop overrides flush/threshold in the very cycle it is first seen
    stopped    = stop || (state_q == StStopped);
    emit       = !stopped && (acc_next_w != '0) &&
                 ((64'(acc_next_w) >= 64'(BATCH_THRESHOLD)) ||
                  (timer_q == TW'(TIMEOUT)) || flush);

    step_d          = '0;
    acc_d           = ACC_WIDTH'(acc_next_w);
    timer_d         = timer_q;
    overflow_d      = overflow_q | sat_hit;
    emitted_total_d = emitted_total_q;

    if (emit) begin
      step_d          = STEP_WIDTH'(amt_w);
      acc_d           = ACC_WIDTH'(acc_next_w - amt_w);
      timer_d         = '0;
      emitted_total_d = emitted_total_q + 64'(amt_w);
    end else if (state_q == StAccum) begin
      if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + TW'(1);
    end else if (state_q == StIdle) begin
      timer_d = '0;
    end

    if (stopped) begin
      state_d = StStopped;
    end else if (acc_d != '0) begin
      state_d = StAccum;
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      acc_q           <= '0;
      timer_q         <= '0;
      step_q          <= '0;
      overflow_q      <= 1'b0;
      emitted_total_q <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      timer_q         <= timer_d;
      step_q          <= step_d;
      overflow_q      <= overflow_d;
      emitted_total_q <= emitted_total_d;
    end
  end

  assign step          = step_q;
  assign pending       = (acc_q != '0);
  assign overflow      = overflow_q;
  assign emitted_total = emitted_total_q;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: default instance, a high-threshold variant
// for partial emissions, and a narrow-accumulator variant for saturation.
module tb_difftest_step_batcher;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // default instance
  logic       tv = 0, fl = 0, st = 0;
  logic [3:0] tc = 0;
  logic [7:0] step;
  logic       pending, overflow;
  logic [63:0] total;

  // BATCH_THRESHOLD = 1024 instance
  logic       b_tv = 0, b_fl = 0, b_st = 0;
  logic [3:0] b_tc = 0;
  logic [7:0] b_step;
  logic       b_pending, b_overflow;
  logic [63:0] b_total;

  // ACC_WIDTH = 6 instance
  logic       s_tv = 0, s_fl = 0, s_st = 0;
  logic [3:0] s_tc = 0;
  logic [7:0] s_step;
  logic       s_pending, s_overflow;
  logic [63:0] s_total;

  difftest_step_batcher dut (
    .clock(clock), .reset(reset), .tick_valid(tv), .tick_count(tc), .flush(fl), .stop(st),
    .step(step), .pending(pending), .overflow(overflow), .emitted_total(total)
  );

  difftest_step_batcher #(.BATCH_THRESHOLD(1024)) dut_big (
    .clock(clock), .reset(reset), .tick_valid(b_tv), .tick_count(b_tc), .flush(b_fl),
    .stop(b_st), .step(b_step), .pending(b_pending), .overflow(b_overflow),
    .emitted_total(b_total)
  );

  difftest_step_batcher #(.ACC_WIDTH(6)) dut_sat (
    .clock(clock), .reset(reset), .tick_valid(s_tv), .tick_count(s_tc), .flush(s_fl),
    .stop(s_st), .step(s_step), .pending(s_pending), .overflow(s_overflow),
    .emitted_total(s_total)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    tv = 0; tc = 0; fl = 0; st = 0;
    b_tv = 0; b_tc = 0; b_fl = 0; b_st = 0;
    s_tv = 0; s_tc = 0; s_fl = 0; s_st = 0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (step !== 8'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0b exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (total !== 64'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total); end
  endtask

  task automatic test_threshold();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tv = 1; tc = 4'd15;
      cyc();
      if (i < 5) begin
        checks++;
        if (step !== 8'd0) begin failures++; $display("FAIL thr_early_step i=%0d got=%0d exp=0", i, step); end
      end
    end
    checks++; if (step !== 8'd75) begin failures++; $display("FAIL thr_step got=%0d exp=75", step); end
    idle_all();
    cyc();
    checks++; if (step !== 8'd0) begin failures++; $display("FAIL thr_single_pulse got=%0d exp=0", step); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL thr_pending got=%0b exp=0", pending); end
    checks++; if (total !== 64'd75) begin failures++; $display("FAIL thr_total got=%0d exp=75", total); end
  endtask

  task automatic test_timeout();
    int first = -1;
    int nz = 0;
    logic [7:0] val = 0;
    do_reset();
    tv = 1; tc = 4'd3;
    cyc();
    idle_all();
    for (int k = 1; k <= 45; k++) begin
      cyc();
      if (step !== 8'd0) begin
        nz++;
        if (first < 0) begin first = k; val = step; end
      end
    end
    checks++; if (first != 32) begin failures++; $display("FAIL to_cycle got=%0d exp=32", first); end
    checks++; if (val !== 8'd3) begin failures++; $display("FAIL to_value got=%0d exp=3", val); end
    checks++; if (nz != 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", nz); end
    checks++; if (total !== 64'd3) begin failures++; $display("FAIL to_total got=%0d exp=3", total); end
  endtask

  task automatic test_flush();
    do_reset();
    tv = 1; tc = 4'd5;
    cyc();
    fl = 1; tc = 4'd3;   // tick in emission cycle is included
    cyc();
    checks++; if (step !== 8'd8) begin failures++; $display("FAIL flush_step got=%0d exp=8", step); end
    tv = 0; tc = 0;       // flush with nothing pending
    cyc();
    checks++; if (step !== 8'd0) begin failures++; $display("FAIL flush_empty got=%0d exp=0", step); end
    fl = 0;
    checks++; if (total !== 64'd8) begin failures++; $display("FAIL flush_total got=%0d exp=8", total); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL flush_pending got=%0b exp=0", pending); end
  endtask

  task automatic test_large_flush();
    int nz = 0;
    int b_nz = 0;
    int first = -1;
    logic [7:0] val = 0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tv = 1; tc = 4'd15; b_tv = 1; b_tc = 4'd15;
      cyc();
      if (step !== 8'd0) begin
        nz++;
        checks++;
        if (step !== 8'd75 || (i % 5) != 0) begin
          failures++; $display("FAIL lf_thr_step i=%0d got=%0d exp=75", i, step);
        end
      end
      if (b_step !== 8'd0) b_nz++;
    end
    checks++; if (nz != 4) begin failures++; $display("FAIL lf_thr_count got=%0d exp=4", nz); end
    checks++; if (b_nz != 0) begin failures++; $display("FAIL lf_big_preload got=%0d exp=0", b_nz); end
    idle_all();
    fl = 1; b_fl = 1;
    cyc();
    fl = 0; b_fl = 0;
    checks++; if (step !== 8'd0) begin failures++; $display("FAIL lf_flush_empty got=%0d exp=0", step); end
    checks++; if (total !== 64'd300) begin failures++; $display("FAIL lf_total got=%0d exp=300", total); end
    checks++; if (b_step !== 8'd255) begin failures++; $display("FAIL lf_big_step got=%0d exp=255", b_step); end
    checks++; if (b_pending !== 1'b1) begin failures++; $display("FAIL lf_big_pending got=%0b exp=1", b_pending); end
    for (int k = 1; k <= 45; k++) begin
      cyc();
      if (b_step !== 8'd0 && first < 0) begin first = k; val = b_step; end
    end
    checks++; if (first != 32) begin failures++; $display("FAIL lf_res_cycle got=%0d exp=32", first); end
    checks++; if (val !== 8'd45) begin failures++; $display("FAIL lf_res_value got=%0d exp=45", val); end
    checks++; if (b_total !== 64'd300) begin failures++; $display("FAIL lf_big_total got=%0d exp=300", b_total); end
    checks++; if (b_pending !== 1'b0) begin failures++; $display("FAIL lf_big_drained got=%0b exp=0", b_pending); end
  endtask

  task automatic test_stop();
    int nz = 0;
    do_reset();
    tv = 1; tc = 4'd15; cyc();
    cyc();
    tc = 4'd10; cyc();
    st = 1; fl = 1; tc = 4'd15;   // stop beats flush
    cyc();
    if (step !== 8'd0) nz++;
    fl = 0;
    for (int i = 0; i < 9; i++) begin cyc(); if (step !== 8'd0) nz++; end
    tv = 0; tc = 0;
    for (int i = 0; i < 40; i++) begin cyc(); if (step !== 8'd0) nz++; end
    st = 0; fl = 1;               // STOPPED is absorbing
    for (int i = 0; i < 5; i++) begin cyc(); if (step !== 8'd0) nz++; end
    fl = 0;
    checks++; if (nz != 0) begin failures++; $display("FAIL stop_steps got=%0d exp=0", nz); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL stop_pending got=%0b exp=1", pending); end
    checks++; if (total !== 64'd0) begin failures++; $display("FAIL stop_total got=%0d exp=0", total); end
  endtask

  task automatic test_saturation();
    do_reset();
    s_st = 1;
    for (int i = 1; i <= 10; i++) begin
      s_tv = 1; s_tc = 4'd15;
      cyc();
      if (i == 4) begin
        checks++;
        if (s_overflow !== 1'b0) begin failures++; $display("FAIL sat_early_ovf got=%0b exp=0", s_overflow); end
      end
    end
    checks++; if (dut_sat.acc_q !== 6'd63) begin failures++; $display("FAIL sat_acc got=%0d exp=63", dut_sat.acc_q); end
    checks++; if (s_overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", s_overflow); end
    s_tv = 0; s_tc = 0;
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (s_overflow !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0b exp=1", s_overflow); end
    checks++; if (s_step !== 8'd0) begin failures++; $display("FAIL sat_step got=%0d exp=0", s_step); end
  endtask

  task automatic test_reset_mid_batch();
    int nz = 0;
    do_reset();
    tv = 1; tc = 4'd15; cyc();
    cyc();
    tc = 4'd10; cyc();
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rmb_pre_pending got=%0b exp=1", pending); end
    do_reset();
    for (int i = 0; i < 50; i++) begin cyc(); if (step !== 8'd0) nz++; end
    checks++; if (nz != 0) begin failures++; $display("FAIL rmb_steps got=%0d exp=0", nz); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rmb_pending got=%0b exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmb_overflow got=%0b exp=0", overflow); end
    checks++; if (total !== 64'd0) begin failures++; $display("FAIL rmb_total got=%0d exp=0", total); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_flush();
    test_large_flush();
    test_stop();
    test_saturation();
    test_reset_mid_batch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
